// File: rtl/axi_stream_mux_pkg.sv
// Shared types and helpers for the registered AXI-stream mux family.
// The round-robin search is sized for the widest mux (8 inputs).
package axi_stream_mux_pkg;

  localparam int MAX_INPUTS     = 8;
  localparam int MAX_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} mux_arb_state_t;

  typedef struct packed {
    logic                      found;
    logic [MAX_ADDR_WIDTH-1:0] index;
  } rr_result_t;

  // First set bit of req strictly after ptr, wrapping at n back to 0.
  function automatic rr_result_t rr_select(input logic [MAX_INPUTS-1:0]     req,
                                           input logic [MAX_ADDR_WIDTH-1:0] ptr,
                                           input int                        n);
    rr_result_t res;
    int         idx;
    res = '0;
    for (int k = 1; k <= MAX_INPUTS; k++) begin
      idx = (int'(ptr) + k) % n;
      if (!res.found && (k <= n) && req[idx[MAX_ADDR_WIDTH-1:0]]) begin
        res.found = 1'b1;
        res.index = idx[MAX_ADDR_WIDTH-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_stream_mux_arbiter_rr_priority_encoder.sv
// Combinational rotate-and-find-first over the request vector.
// sel is only meaningful while any is high.
module rr_priority_encoder
  import axi_stream_mux_pkg::*;
#(
  parameter int N_INPUTS   = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic [N_INPUTS-1:0]   req,
  input  logic [ADDR_WIDTH-1:0] ptr,
  output logic [ADDR_WIDTH-1:0] sel,
  output logic                  any
);

  logic [MAX_INPUTS-1:0] req_wide;
  rr_result_t            result;

  always_comb begin
    req_wide               = '0;
    req_wide[N_INPUTS-1:0] = req;
    result                 = rr_select(req_wide, MAX_ADDR_WIDTH'(ptr), N_INPUTS);
    sel                    = ADDR_WIDTH'(result.index);
    any                    = result.found;
  end

endmodule

// File: rtl/axi_stream_mux_arbiter.sv
// Packet-aware round-robin arbiter producing the select of the registered
// AXI-stream mux; a grant is held until tlast is accepted or the input stalls out.
module axi_stream_mux_arbiter
  import axi_stream_mux_pkg::*;
#(
  parameter int N_INPUTS   = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int TIMEOUT    = 1024,
  parameter int SWITCH_GAP = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [N_INPUTS-1:0]   in_valid,
  input  logic [N_INPUTS-1:0]   in_ready,
  input  logic [N_INPUTS-1:0]   in_tlast,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [N_INPUTS-1:0]   grant,
  output logic                  busy,
  output logic                  timeout_flag
);

  localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GAP_WIDTH = (SWITCH_GAP > 1) ? $clog2(SWITCH_GAP) : 1;
  localparam logic [CNT_WIDTH-1:0]  STALL_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GAP_WIDTH-1:0]  GAP_LAST   = GAP_WIDTH'((SWITCH_GAP > 0) ? SWITCH_GAP - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(N_INPUTS - 1);

  mux_arb_state_t        state;
  mux_arb_state_t        state_next;
  logic [ADDR_WIDTH-1:0] rr_ptr;
  logic [ADDR_WIDTH-1:0] sel;
  logic                  any_req;
  logic                  beat;
  logic                  end_beat;
  logic                  stall_expired;
  logic                  start_grant;
  logic [CNT_WIDTH-1:0]  stall_cnt;
  logic [GAP_WIDTH-1:0]  gap_cnt;
  logic [ADDR_WIDTH-1:0] address_next;
  logic [N_INPUTS-1:0]   grant_next;
  logic                  busy_next;

  rr_priority_encoder #(
    .N_INPUTS  (N_INPUTS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_encoder (
    .req(in_valid),
    .ptr(rr_ptr),
    .sel(sel),
    .any(any_req)
  );

  // grant is all-zero outside GRANT, so masking with it ignores every other input.
  assign beat          = |(in_valid & in_ready & grant);
  assign end_beat      = |(in_valid & in_ready & in_tlast & grant);
  assign stall_expired = (TIMEOUT != 0) && (state == GRANT) && !beat && (stall_cnt == STALL_LAST);
  assign start_grant   = (state == IDLE) && enable && any_req;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rr_ptr       <= LAST_INDEX;
      address      <= '0;
      grant        <= '0;
      busy         <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_next;
      address      <= address_next;
      grant        <= grant_next;
      busy         <= busy_next;
      timeout_flag <= stall_expired;
      if (start_grant) begin
        rr_ptr <= sel;
      end
    end
  end

  // An end beat implies a beat, so it always takes precedence over the stall abort.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_grant) state_next = GRANT;
      GRANT:   if (end_beat || stall_expired) state_next = (SWITCH_GAP == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    address_next = address;
    grant_next   = '0;
    if (start_grant) begin
      address_next = sel;
    end
    if (state_next == GRANT) begin
      grant_next[address_next] = 1'b1;
    end
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if ((state != GRANT) || beat || (TIMEOUT == 0)) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gap_cnt <= '0;
    end else if (state == GAP) begin
      gap_cnt <= gap_cnt + GAP_WIDTH'(1);
    end else begin
      gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_axi_stream_mux_arbiter.sv
// Scoreboard bench for axi_stream_mux_arbiter: directed stimulus queues expected
// grant/timeout events with their cycle stamps; a monitor pops them as they appear.
module tb_axi_stream_mux_arbiter;

  localparam int N  = 6;
  localparam int AW = 3;

  typedef enum int {EV_GRANT, EV_TIMEOUT} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       idx;
    int       cyc;
  } ev_t;

  logic          clock    = 1'b0;
  logic          reset    = 1'b0;
  logic          enable   = 1'b0;
  logic [N-1:0]  in_valid = '0;
  logic [N-1:0]  in_ready = '0;
  logic [N-1:0]  in_tlast = '0;
  logic [AW-1:0] address;
  logic [N-1:0]  grant;
  logic          busy;
  logic          timeout_flag;

  int           cyc   = 0;
  int           total = 0;
  int           bad   = 0;
  ev_t          expq[$];
  logic [N-1:0] prevGrant = '0;

  axi_stream_mux_arbiter #(
    .N_INPUTS  (N),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (16),
    .SWITCH_GAP(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_tlast    (in_tlast),
    .address     (address),
    .grant       (grant),
    .busy        (busy),
    .timeout_flag(timeout_flag)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic en, input logic [N-1:0] v,
                               input logic [N-1:0] r, input logic [N-1:0] t);
    enable   = en;
    in_valid = v;
    in_ready = r;
    in_tlast = t;
  endtask

  task automatic expectEvent(input ev_kind_t kind, input int idx, input int when);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.cyc  = when;
    expq.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input logic [AW-1:0] expAddr,
                             input logic [N-1:0] expGrant, input logic expBusy,
                             input logic expFlag);
    total++;
    if (address !== expAddr || grant !== expGrant || busy !== expBusy || timeout_flag !== expFlag) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got address=%0d grant=%b busy=%b flag=%b, want address=%0d grant=%b busy=%b flag=%b",
               tag, cyc, address, grant, busy, timeout_flag, expAddr, expGrant, expBusy, expFlag);
    end
  endtask

  task automatic checkEvent(input ev_kind_t kind);
    ev_t          e;
    logic [N-1:0] expGrant;
    total++;
    if (expq.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected %s at cycle %0d: address=%0d grant=%b, want no event",
               kind.name(), cyc, address, grant);
    end else begin
      e        = expq.pop_front();
      expGrant = '0;
      if (e.kind == EV_GRANT) expGrant[e.idx] = 1'b1;
      if (kind != e.kind || cyc != e.cyc || int'(address) != e.idx || grant !== expGrant) begin
        bad++;
        $display("[TB] FAIL event: got %s address=%0d grant=%b cycle=%0d, want %s address=%0d grant=%b cycle=%0d",
                 kind.name(), address, grant, cyc, e.kind.name(), e.idx, expGrant, e.cyc);
      end
    end
  endtask

  // Monitor: a grant rising from all-zero or a timeout pulse is an observable event.
  always @(negedge clock) begin
    if (!reset) begin
      prevGrant <= '0;
    end else begin
      if (grant != '0 && prevGrant == '0) checkEvent(EV_GRANT);
      if (timeout_flag) checkEvent(EV_TIMEOUT);
      prevGrant <= grant;
    end
  end

  initial begin
    int c;
    int order[7];
    order = '{0, 1, 2, 3, 4, 5, 0};

    applyStimulus(1'b0, '0, '0, '0);
    tick;
    tick;
    checkOutput("reset values", '0, '0, 1'b0, 1'b0);
    reset = 1'b1;

    // Single 4-beat packet on input 2.
    tick;
    c = cyc;
    applyStimulus(1'b1, 6'b000100, 6'b000100, 6'b000000);
    expectEvent(EV_GRANT, 2, c + 1);
    for (int k = 1; k <= 4; k++) begin
      tick;
      checkOutput("t1 hold", 3'd2, 6'b000100, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 6'b000100, 6'b000100, 6'b000100);
    tick;
    checkOutput("t1 release", 3'd2, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, '0, '0, '0);
    tick;
    checkOutput("t1 gap", 3'd2, '0, 1'b1, 1'b0);
    tick;
    checkOutput("t1 idle", 3'd2, '0, 1'b0, 1'b0);

    // Round robin with every input requesting single-beat packets.
    reset = 1'b0;
    tick;
    checkOutput("reset again", '0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    c = cyc;
    applyStimulus(1'b1, 6'b111111, 6'b111111, 6'b111111);
    for (int k = 0; k < 7; k++) expectEvent(EV_GRANT, order[k], c + 1 + 4 * k);
    repeat (26) tick;
    checkOutput("t2 last release", 3'd0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, '0, '0, '0);
    repeat (3) tick;

    // Input 3 stalls and is aborted; input 4 is served next.
    c = cyc;
    applyStimulus(1'b1, 6'b011000, 6'b010000, 6'b010000);
    expectEvent(EV_GRANT, 3, c + 1);
    expectEvent(EV_TIMEOUT, 3, c + 17);
    expectEvent(EV_GRANT, 4, c + 20);
    repeat (16) tick;
    checkOutput("t3 before abort", 3'd3, 6'b001000, 1'b1, 1'b0);
    tick;
    checkOutput("t3 abort", 3'd3, '0, 1'b1, 1'b1);
    tick;
    checkOutput("t3 pulse end", 3'd3, '0, 1'b1, 1'b0);
    repeat (3) tick;
    applyStimulus(1'b1, '0, '0, '0);
    repeat (3) tick;

    // End beat lands on the terminal stall count.
    c = cyc;
    applyStimulus(1'b1, 6'b000001, 6'b000000, 6'b000001);
    expectEvent(EV_GRANT, 0, c + 1);
    repeat (16) tick;
    checkOutput("t4 terminal", 3'd0, 6'b000001, 1'b1, 1'b0);
    applyStimulus(1'b1, 6'b000001, 6'b000001, 6'b000001);
    tick;
    checkOutput("t4 end wins", 3'd0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, '0, '0, '0);
    tick;
    checkOutput("t4 no flag", 3'd0, '0, 1'b1, 1'b0);
    repeat (2) tick;

    // enable drops mid-packet on input 1, then parks until re-enabled.
    c = cyc;
    applyStimulus(1'b1, 6'b000010, 6'b000010, 6'b000000);
    expectEvent(EV_GRANT, 1, c + 1);
    tick;
    applyStimulus(1'b0, 6'b000010, 6'b000010, 6'b000000);
    tick;
    tick;
    applyStimulus(1'b0, 6'b000010, 6'b000010, 6'b000010);
    tick;
    checkOutput("t5 packet done", 3'd1, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, 6'b100001, 6'b000000, 6'b000000);
    repeat (8) tick;
    checkOutput("t5 parked", 3'd1, '0, 1'b0, 1'b0);
    expectEvent(EV_GRANT, 5, c + 13);
    applyStimulus(1'b1, 6'b100001, 6'b000000, 6'b000000);
    tick;
    applyStimulus(1'b1, 6'b100001, 6'b100000, 6'b100000);
    tick;
    applyStimulus(1'b1, '0, '0, '0);
    repeat (3) tick;

    // Reset mid-packet on input 4; the search restarts at input 0.
    c = cyc;
    applyStimulus(1'b1, 6'b010000, 6'b010000, 6'b000000);
    expectEvent(EV_GRANT, 4, c + 1);
    repeat (3) tick;
    checkOutput("t6 mid packet", 3'd4, 6'b010000, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1 checkOutput("t6 async reset", '0, '0, 1'b0, 1'b0);
    tick;
    tick;
    reset = 1'b1;
    c = cyc;
    applyStimulus(1'b1, 6'b100001, 6'b000001, 6'b000001);
    expectEvent(EV_GRANT, 0, c + 1);
    tick;
    checkOutput("t6 restart", 3'd0, 6'b000001, 1'b1, 1'b0);
    tick;
    applyStimulus(1'b1, '0, '0, '0);
    repeat (6) tick;
    checkOutput("final idle", 3'd0, '0, 1'b0, 1'b0);

    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("[TB] FAIL queue drain: %0d events still pending, want 0", expq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
